vga_pixel_timing_ctrl: RTL and testbench

//  Pixel-timing source and colour sink of the VGA pixel interface.
//  - Generates pixelX/pixelY scan coordinates for all drawing blocks: background, objects, mux.
//  - Captures the resulting 8-bit RGB332 pixel, RGB_LATENCY pixel ticks later.
//  - Drives 4-bit-per-channel DAC colour plus hSync/vSync, aligned so each colour meets its syncs.
//  - Sits between the drawing chain and the board VGA connector.

---
 rtl/vga_timing_pkg.sv | 50 +++++
 rtl/vga_sync_delay.sv | 37 +++
 rtl/vga_pixel_timing_ctrl.sv | 132 +++++++++++++
 tb/tb_vga_pixel_timing_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, colour formats and the RGB332 -> RGB444 expansion
// used by the pixel-timing controller.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF    = 640;
  localparam int H_FP_DEF        = 16;
  localparam int H_SYNC_DEF      = 96;
  localparam int H_BP_DEF        = 48;
  localparam int V_ACTIVE_DEF    = 480;
  localparam int V_FP_DEF        = 10;
  localparam int V_SYNC_DEF      = 2;
  localparam int V_BP_DEF        = 33;
  localparam int RGB_LATENCY_DEF = 1;
  localparam logic SYNC_POL_DEF  = 1'b0;

  localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int CNT_W = 11;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Per-pixel decode carried alongside the drawing chain's latency.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } sync_flags_t;

  // Replicate the MSBs so full-scale 3-bit and 2-bit codes reach 4'hF.
  function automatic rgb444_t expand332to444(input rgb332_t c);
    rgb444_t o;
    o.r = {c.r, c.r[2]};
    o.g = {c.g, c.g[2]};
    o.b = {c.b, c.b};
    return o;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Enable-gated shift register of configurable depth; clears to all-zero
// (blank, syncs inactive) on reset.
module vga_sync_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] r_q;
      logic [WIDTH-1:0] w_src;

      if (gi == 0) begin : g_head
        assign w_src = i_d;
      end else begin : g_tail
        assign w_src = g_stage[gi-1].r_q;
      end

      always_ff @(posedge clk) begin
        if (i_reset) begin
          r_q <= '0;
        end else if (i_en) begin
          r_q <= w_src;
        end
      end
    end
  endgenerate

  assign o_q = g_stage[DEPTH-1].r_q;

endmodule

// File: rtl/vga_pixel_timing_ctrl.sv
// VGA pixel-timing source: scan counters, sync decode delayed to match the
// drawing chain's RGB latency, and registered DAC colour and sync outputs.
module vga_pixel_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE    = H_ACTIVE_DEF,
  parameter int   H_FP        = H_FP_DEF,
  parameter int   H_SYNC      = H_SYNC_DEF,
  parameter int   H_BP        = H_BP_DEF,
  parameter int   V_ACTIVE    = V_ACTIVE_DEF,
  parameter int   V_FP        = V_FP_DEF,
  parameter int   V_SYNC      = V_SYNC_DEF,
  parameter int   V_BP        = V_BP_DEF,
  parameter int   RGB_LATENCY = RGB_LATENCY_DEF,
  parameter logic SYNC_POL    = SYNC_POL_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixelEn,
  input  logic [7:0]  RGB_in,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hSync,
  output logic        vSync
);

  localparam int L_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int L_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam cnt_t L_H_LAST = cnt_t'(L_H_TOTAL - 1);
  localparam cnt_t L_V_LAST = cnt_t'(L_V_TOTAL - 1);
  localparam cnt_t L_H_ACT  = cnt_t'(H_ACTIVE);
  localparam cnt_t L_V_ACT  = cnt_t'(V_ACTIVE);
  localparam cnt_t L_HS_BEG = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t L_HS_END = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t L_VS_BEG = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t L_VS_END = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  cnt_t        r_pixel_x;
  cnt_t        r_pixel_y;
  logic        r_sof;
  logic [3:0]  r_red;
  logic [3:0]  r_green;
  logic [3:0]  r_blue;
  logic        r_hsync;
  logic        r_vsync;

  sync_flags_t w_flags;
  sync_flags_t w_dly;
  rgb444_t     w_rgb444;

  // Scan counters; line and frame wrap resolve on the same tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pixel_x <= '0;
      r_pixel_y <= '0;
      r_sof     <= 1'b0;
    end else begin
      r_sof <= 1'b0;
      if (pixelEn) begin
        if (r_pixel_x == L_H_LAST) begin
          r_pixel_x <= '0;
          if (r_pixel_y == L_V_LAST) begin
            r_pixel_y <= '0;
            r_sof     <= 1'b1;
          end else begin
            r_pixel_y <= r_pixel_y + cnt_t'(1);
          end
        end else begin
          r_pixel_x <= r_pixel_x + cnt_t'(1);
        end
      end
    end
  end

  always_comb begin
    w_flags        = '0;
    w_flags.active = (r_pixel_x < L_H_ACT) && (r_pixel_y < L_V_ACT);
    w_flags.hs     = (r_pixel_x >= L_HS_BEG) && (r_pixel_x < L_HS_END);
    w_flags.vs     = (r_pixel_y >= L_VS_BEG) && (r_pixel_y < L_VS_END);
  end

  vga_sync_delay #(
    .DEPTH (RGB_LATENCY),
    .WIDTH ($bits(sync_flags_t))
  ) u_sync_delay (
    .clk     (clk),
    .i_reset (reset),
    .i_en    (pixelEn),
    .i_d     (w_flags),
    .o_q     (w_dly)
  );

  assign w_rgb444 = expand332to444(rgb332_t'(RGB_in));

  // RGB_in now belongs to the same pixel as w_dly; blanking forces black.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
    end else if (pixelEn) begin
      r_hsync <= w_dly.hs ? SYNC_POL : ~SYNC_POL;
      r_vsync <= w_dly.vs ? SYNC_POL : ~SYNC_POL;
      if (w_dly.active) begin
        r_red   <= w_rgb444.r;
        r_green <= w_rgb444.g;
        r_blue  <= w_rgb444.b;
      end else begin
        r_red   <= '0;
        r_green <= '0;
        r_blue  <= '0;
      end
    end
  end

  assign pixelX       = r_pixel_x;
  assign pixelY       = r_pixel_y;
  assign startOfFrame = r_sof;
  assign red          = r_red;
  assign green        = r_green;
  assign blue         = r_blue;
  assign hSync        = r_hsync;
  assign vSync        = r_vsync;

endmodule

// File: tb/tb_vga_pixel_timing_ctrl.sv
// Bench for vga_pixel_timing_ctrl: two reduced-timing instances (latency 1 /
// active-low, latency 2 / active-high) plus one instance at the default timing.
module tb_vga_pixel_timing_ctrl;

  localparam int SH_ACT  = 16;
  localparam int SH_FP   = 2;
  localparam int SH_SYNC = 4;
  localparam int SH_BP   = 3;
  localparam int SV_ACT  = 8;
  localparam int SV_FP   = 1;
  localparam int SV_SYNC = 2;
  localparam int SV_BP   = 2;
  localparam int SH_TOT  = SH_ACT + SH_FP + SH_SYNC + SH_BP;
  localparam int SV_TOT  = SV_ACT + SV_FP + SV_SYNC + SV_BP;
  localparam int S_FRAME = SH_TOT * SV_TOT;

  logic        clk;
  logic        reset;
  logic        pixel_en;
  logic [7:0]  rgb_a, rgb_b, rgb_c;
  logic [10:0] px_a, py_a, px_b, py_b, px_c, py_c;
  logic        sof_a, sof_b, sof_c;
  logic [3:0]  red_a, green_a, blue_a, red_b, green_b, blue_b, red_c, green_c, blue_c;
  logic        hs_a, vs_a, hs_b, vs_b, hs_c, vs_c;

  logic [36:0] obs_a, obs_b, exp_a, exp_b;
  assign obs_a = {px_a, py_a, sof_a, red_a, green_a, blue_a, hs_a, vs_a};
  assign obs_b = {px_b, py_b, sof_b, red_b, green_b, blue_b, hs_b, vs_b};

  int n_vec = 0;
  int n_err = 0;

  // Reference model state for the reduced-timing instances.
  int          mx, my, tick_idx, rgb_mode;
  logic        m_sof;
  logic [7:0]  hc [2];
  logic [13:0] qa [$];
  logic [13:0] qb [$];
  logic [13:0] cur_a, cur_b;

  vga_pixel_timing_ctrl #(
    .H_ACTIVE(SH_ACT), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_ACTIVE(SV_ACT), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP),
    .RGB_LATENCY(1), .SYNC_POL(1'b0)
  ) dut_a (
    .clk(clk), .reset(reset), .pixelEn(pixel_en), .RGB_in(rgb_a),
    .pixelX(px_a), .pixelY(py_a), .startOfFrame(sof_a),
    .red(red_a), .green(green_a), .blue(blue_a), .hSync(hs_a), .vSync(vs_a)
  );

  vga_pixel_timing_ctrl #(
    .H_ACTIVE(SH_ACT), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_ACTIVE(SV_ACT), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP),
    .RGB_LATENCY(2), .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset), .pixelEn(pixel_en), .RGB_in(rgb_b),
    .pixelX(px_b), .pixelY(py_b), .startOfFrame(sof_b),
    .red(red_b), .green(green_b), .blue(blue_b), .hSync(hs_b), .vSync(vs_b)
  );

  vga_pixel_timing_ctrl dut_c (
    .clk(clk), .reset(reset), .pixelEn(pixel_en), .RGB_in(rgb_c),
    .pixelX(px_c), .pixelY(py_c), .startOfFrame(sof_c),
    .red(red_c), .green(green_c), .blue(blue_c), .hSync(hs_c), .vSync(vs_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int x, input int y);
    case (rgb_mode)
      0:       return 8'hE3;
      1:       return x[7:0];
      default: return 8'(x * 37 + y * 91 + 5);
    endcase
  endfunction

  function automatic logic [13:0] model_pins(input int x, input int y,
                                             input logic [7:0] c, input logic pol);
    logic        act, hs, vs;
    logic [11:0] col;
    act = (x < SH_ACT) && (y < SV_ACT);
    hs  = (x >= SH_ACT + SH_FP) && (x < SH_ACT + SH_FP + SH_SYNC);
    vs  = (y >= SV_ACT + SV_FP) && (y < SV_ACT + SV_FP + SV_SYNC);
    col = act ? {c[7:5], c[7], c[4:2], c[4], c[1:0], c[1:0]} : 12'h000;
    return {col, hs ? pol : ~pol, vs ? pol : ~pol};
  endfunction

  // One clock: drive inputs, advance the model, push new expectations and
  // pop the ones the pins are due to show now.
  task automatic step(input logic en, input logic rst);
    logic [7:0] c;
    pixel_en = en;
    reset    = rst;
    rgb_a    = hc[0];
    rgb_b    = hc[1];
    rgb_c    = 8'hE3;
    @(posedge clk);
    m_sof = 1'b0;
    if (rst) begin
      mx = 0; my = 0; tick_idx = 0;
      hc[0] = 8'h00; hc[1] = 8'h00;
      qa.delete(); qb.delete();
      qa.push_back({12'h000, 2'b11});
      qb.push_back({12'h000, 2'b00});
      qb.push_back({12'h000, 2'b00});
      cur_a = {12'h000, 2'b11};
      cur_b = {12'h000, 2'b00};
    end else begin
      tick_idx++;
      if (en) begin
        c = pat(mx, my);
        qa.push_back(model_pins(mx, my, c, 1'b0));
        qb.push_back(model_pins(mx, my, c, 1'b1));
        hc[1] = hc[0];
        hc[0] = c;
        if (mx == SH_TOT - 1) begin
          mx = 0;
          if (my == SV_TOT - 1) begin
            my = 0;
            m_sof = 1'b1;
          end else begin
            my++;
          end
        end else begin
          mx++;
        end
        while (qa.size() > 1) cur_a = qa.pop_front();
        while (qb.size() > 2) cur_b = qb.pop_front();
      end
    end
    exp_a = {11'(mx), 11'(my), m_sof, cur_a};
    exp_b = {11'(mx), 11'(my), m_sof, cur_b};
    #1;
  endtask

  task automatic test_reset();
    logic [36:0] want_a, want_b, want_c, got_c;
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    want_a = {11'd0, 11'd0, 1'b0, 12'h000, 2'b11};
    want_b = {11'd0, 11'd0, 1'b0, 12'h000, 2'b00};
    want_c = {11'd0, 11'd0, 1'b0, 12'h000, 2'b11};
    got_c  = {px_c, py_c, sof_c, red_c, green_c, blue_c, hs_c, vs_c};
    n_vec++; if (obs_a !== want_a) begin n_err++; $display("FAIL reset_a got=%h want=%h", obs_a, want_a); end
    n_vec++; if (obs_b !== want_b) begin n_err++; $display("FAIL reset_b got=%h want=%h", obs_b, want_b); end
    n_vec++; if (got_c !== want_c) begin n_err++; $display("FAIL reset_c got=%h want=%h", got_c, want_c); end
    $display("reset: outputs checked on all instances");
  endtask

  task automatic test_frame();
    int sof_n = 0, hs_a_n = 0, vs_a_n = 0, hs_b_n = 0, vs_b_n = 0;
    rgb_mode = 0;
    step(1'b1, 1'b1);
    for (int i = 0; i < S_FRAME + 6; i++) begin
      step(1'b1, 1'b0);
      n_vec++; if (obs_a !== exp_a) begin n_err++; $display("FAIL frame_a t=%0d got=%h want=%h", tick_idx, obs_a, exp_a); end
      n_vec++; if (obs_b !== exp_b) begin n_err++; $display("FAIL frame_b t=%0d got=%h want=%h", tick_idx, obs_b, exp_b); end
      if (sof_a) sof_n++;
      if (i >= 6) begin
        if (!hs_a) hs_a_n++;
        if (!vs_a) vs_a_n++;
        if (hs_b)  hs_b_n++;
        if (vs_b)  vs_b_n++;
      end
    end
    n_vec++; if (sof_n != 1) begin n_err++; $display("FAIL sof_count got=%0d want=1", sof_n); end
    n_vec++; if (hs_a_n != SH_SYNC * SV_TOT) begin n_err++; $display("FAIL hs_low_a got=%0d want=%0d", hs_a_n, SH_SYNC * SV_TOT); end
    n_vec++; if (vs_a_n != SV_SYNC * SH_TOT) begin n_err++; $display("FAIL vs_low_a got=%0d want=%0d", vs_a_n, SV_SYNC * SH_TOT); end
    n_vec++; if (hs_b_n != SH_SYNC * SV_TOT) begin n_err++; $display("FAIL hs_high_b got=%0d want=%0d", hs_b_n, SH_SYNC * SV_TOT); end
    n_vec++; if (vs_b_n != SV_SYNC * SH_TOT) begin n_err++; $display("FAIL vs_high_b got=%0d want=%0d", vs_b_n, SV_SYNC * SH_TOT); end
    $display("frame: constant E3, %0d sof pulses, hs_a low %0d clks", sof_n, hs_a_n);
  endtask

  task automatic test_pattern();
    int first_hs_a = -1, first_hs_b = -1;
    rgb_mode = 1;
    step(1'b1, 1'b1);
    for (int i = 0; i < S_FRAME + 4; i++) begin
      step(1'b1, 1'b0);
      n_vec++; if (obs_a !== exp_a) begin n_err++; $display("FAIL xpat_a t=%0d got=%h want=%h", tick_idx, obs_a, exp_a); end
      n_vec++; if (obs_b !== exp_b) begin n_err++; $display("FAIL xpat_b t=%0d got=%h want=%h", tick_idx, obs_b, exp_b); end
      if (first_hs_a < 0 && !hs_a) first_hs_a = tick_idx;
      if (first_hs_b < 0 && hs_b)  first_hs_b = tick_idx;
      if (tick_idx == 3) begin
        n_vec++; if (blue_a !== 4'b0101) begin n_err++; $display("FAIL px1_a blue got=%h want=5", blue_a); end
        n_vec++; if ({red_b, green_b, blue_b} !== 12'h000) begin n_err++; $display("FAIL px0_b got=%h want=000", {red_b, green_b, blue_b}); end
      end
      if (tick_idx == 4) begin
        n_vec++; if (blue_b !== 4'b0101) begin n_err++; $display("FAIL px1_b blue got=%h want=5", blue_b); end
      end
    end
    n_vec++; if (first_hs_a != SH_ACT + SH_FP + 2) begin n_err++; $display("FAIL hs_edge_a got=%0d want=%0d", first_hs_a, SH_ACT + SH_FP + 2); end
    n_vec++; if (first_hs_b != SH_ACT + SH_FP + 3) begin n_err++; $display("FAIL hs_edge_b got=%0d want=%0d", first_hs_b, SH_ACT + SH_FP + 3); end
    rgb_mode = 2;
    for (int i = 0; i < S_FRAME; i++) begin
      step(1'b1, 1'b0);
      n_vec++; if (obs_a !== exp_a) begin n_err++; $display("FAIL mix_a t=%0d got=%h want=%h", tick_idx, obs_a, exp_a); end
      n_vec++; if (obs_b !== exp_b) begin n_err++; $display("FAIL mix_b t=%0d got=%h want=%h", tick_idx, obs_b, exp_b); end
    end
    $display("pattern: hsync edges a=%0d b=%0d", first_hs_a, first_hs_b);
  endtask

  task automatic test_pixel_en_toggle();
    int wrap1 = -1, wrap2 = -1;
    logic [10:0] prev_x = 11'd0;
    rgb_mode = 2;
    step(1'b1, 1'b1);
    for (int i = 0; i < 2 * S_FRAME + 20; i++) begin
      step((i % 2) == 0, 1'b0);
      n_vec++; if (obs_a !== exp_a) begin n_err++; $display("FAIL toggle_a t=%0d got=%h want=%h", tick_idx, obs_a, exp_a); end
      n_vec++; if (obs_b !== exp_b) begin n_err++; $display("FAIL toggle_b t=%0d got=%h want=%h", tick_idx, obs_b, exp_b); end
      if (px_a == 11'd0 && prev_x != 11'd0) begin
        if (wrap1 < 0) wrap1 = tick_idx;
        else if (wrap2 < 0) wrap2 = tick_idx;
      end
      prev_x = px_a;
    end
    n_vec++; if (wrap1 != 2 * SH_TOT - 1) begin n_err++; $display("FAIL first_wrap got=%0d want=%0d", wrap1, 2 * SH_TOT - 1); end
    n_vec++; if (wrap2 - wrap1 != 2 * SH_TOT) begin n_err++; $display("FAIL line_period got=%0d want=%0d", wrap2 - wrap1, 2 * SH_TOT); end
    $display("pixel_en toggle: line period %0d clks", wrap2 - wrap1);
  endtask

  task automatic test_mid_reset();
    int tx, ty;
    rgb_mode = 2;
    for (int k = 0; k < 2; k++) begin
      tx = (k == 0) ? 12 : 20;
      ty = (k == 0) ? 6 : 9;
      step(1'b1, 1'b1);
      for (int g = 0; g < 2 * S_FRAME && !(mx == tx && my == ty); g++) begin
        step(1'b1, 1'b0);
        n_vec++; if (obs_a !== exp_a) begin n_err++; $display("FAIL pre_rst_a t=%0d got=%h want=%h", tick_idx, obs_a, exp_a); end
        n_vec++; if (obs_b !== exp_b) begin n_err++; $display("FAIL pre_rst_b t=%0d got=%h want=%h", tick_idx, obs_b, exp_b); end
      end
      step(1'b1, 1'b1);
      n_vec++; if (obs_a !== {11'd0, 11'd0, 1'b0, 12'h000, 2'b11}) begin n_err++; $display("FAIL mid_rst_a got=%h", obs_a); end
      n_vec++; if (obs_b !== {11'd0, 11'd0, 1'b0, 12'h000, 2'b00}) begin n_err++; $display("FAIL mid_rst_b got=%h", obs_b); end
      for (int i = 0; i < S_FRAME + 3; i++) begin
        step(1'b1, 1'b0);
        n_vec++; if (obs_a !== exp_a) begin n_err++; $display("FAIL post_rst_a t=%0d got=%h want=%h", tick_idx, obs_a, exp_a); end
        n_vec++; if (obs_b !== exp_b) begin n_err++; $display("FAIL post_rst_b t=%0d got=%h want=%h", tick_idx, obs_b, exp_b); end
      end
      $display("mid-frame reset at (%0d,%0d) and resumed frame checked", tx, ty);
    end
  endtask

  task automatic test_default_line();
    int hs_low = 0, first_low = -1, vs_low = 0;
    step(1'b1, 1'b1);
    for (int i = 0; i < 1700; i++) begin
      step(1'b1, 1'b0);
      n_vec++;
      if (px_c !== 11'(tick_idx % 800) || py_c !== 11'(tick_idx / 800)) begin
        n_err++;
        $display("FAIL dflt_xy t=%0d got=(%0d,%0d) want=(%0d,%0d)", tick_idx, px_c, py_c, tick_idx % 800, tick_idx / 800);
      end
      if (!hs_c) begin
        hs_low++;
        if (first_low < 0) first_low = tick_idx;
      end
      if (!vs_c) vs_low++;
      if (tick_idx == 2 || tick_idx == 641) begin
        n_vec++; if ({red_c, green_c, blue_c} !== 12'hF0F) begin n_err++; $display("FAIL dflt_visible t=%0d got=%h want=F0F", tick_idx, {red_c, green_c, blue_c}); end
      end
      if (tick_idx == 642) begin
        n_vec++; if ({red_c, green_c, blue_c} !== 12'h000) begin n_err++; $display("FAIL dflt_blank t=%0d got=%h want=000", tick_idx, {red_c, green_c, blue_c}); end
      end
    end
    n_vec++; if (first_low != 658) begin n_err++; $display("FAIL dflt_hs_edge got=%0d want=658", first_low); end
    n_vec++; if (hs_low != 192) begin n_err++; $display("FAIL dflt_hs_width got=%0d want=192", hs_low); end
    n_vec++; if (vs_low != 0) begin n_err++; $display("FAIL dflt_vs got=%0d want=0", vs_low); end
    $display("default timing: hsync low from %0d, %0d clks over 2 lines", first_low, hs_low);
  endtask

  initial begin
    reset    = 1'b1;
    pixel_en = 1'b0;
    rgb_a    = 8'h00;
    rgb_b    = 8'h00;
    rgb_c    = 8'h00;
    rgb_mode = 0;
    hc[0]    = 8'h00;
    hc[1]    = 8'h00;
    test_reset();
    test_frame();
    test_pattern();
    test_pixel_en_toggle();
    test_mid_reset();
    test_default_line();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired vectors=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule
